// File: rtl/pilha_if.sv
// Stack strobe/data bundle between the control unit (master) and the operand stack (slave).
interface pilha_if #(
  parameter int DATA_W = 16,
  parameter int SP_W   = 5
);
  logic              push;
  logic              pop;
  logic              controle_pilha;
  logic [DATA_W-1:0] data_pilha;
  logic [DATA_W-1:0] data_ula;
  logic [DATA_W-1:0] topo;
  logic [DATA_W-1:0] segundo;
  logic [SP_W-1:0]   sp;
  logic              vazia;
  logic              cheia;
  logic              pop_valid;
  logic [DATA_W-1:0] dado_pop;
  logic              erro_overflow;
  logic              erro_underflow;

  modport master (
    output push, pop, controle_pilha, data_pilha, data_ula,
    input  topo, segundo, sp, vazia, cheia, pop_valid, dado_pop,
           erro_overflow, erro_underflow
  );

  modport slave (
    input  push, pop, controle_pilha, data_pilha, data_ula,
    output topo, segundo, sp, vazia, cheia, pop_valid, dado_pop,
           erro_overflow, erro_underflow
  );
endinterface

// File: rtl/pilha.sv
// Operand stack for the 16-bit stack processor: push / pop / replace-top, registered status.
// Optional sticky overflow/underflow flags are built only when PILHA_ERROS_EN is defined.
module pilha #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int SP_W   = 5
) (
  input logic   clock,
  input logic   reset,
  pilha_if.slave bus
);
  localparam logic [SP_W-1:0] ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] TWO  = SP_W'(2);
  localparam logic [SP_W-1:0] FULL = SP_W'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem, mem_n;
  logic [SP_W-1:0]   sp_q, sp_n, sp_m1, nt, ns;
  logic [DATA_W-1:0] din, topo_q, segundo_q, dado_pop_q;
  logic              vazia_q, cheia_q, pop_valid_q, pop_acc;

  always_comb begin
    din     = bus.controle_pilha ? bus.data_ula : bus.data_pilha;
    mem_n   = mem;
    sp_n    = sp_q;
    pop_acc = 1'b0;
    sp_m1   = sp_q - ONE;
    case ({bus.push, bus.pop})
      2'b10: if (sp_q != FULL) begin
        mem_n[sp_q[SP_W-2:0]] = din;
        sp_n = sp_q + ONE;
      end
      2'b01: if (sp_q != '0) begin
        pop_acc = 1'b1;
        sp_n    = sp_m1;
      end
      2'b11: if (sp_q != '0) begin
        pop_acc = 1'b1;
        mem_n[sp_m1[SP_W-2:0]] = din;
      end else begin
        // Replace on empty degrades to a plain push.
        mem_n[0] = din;
        sp_n     = ONE;
      end
      default: ;
    endcase
    nt = sp_n - ONE;
    ns = sp_n - TWO;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q        <= '0;
      topo_q      <= '0;
      segundo_q   <= '0;
      vazia_q     <= 1'b1;
      cheia_q     <= 1'b0;
      pop_valid_q <= 1'b0;
      dado_pop_q  <= '0;
    end else begin
      mem         <= mem_n;
      sp_q        <= sp_n;
      // Top views come from next-state so they line up with sp.
      topo_q      <= (sp_n != '0) ? mem_n[nt[SP_W-2:0]] : '0;
      segundo_q   <= (sp_n >= TWO) ? mem_n[ns[SP_W-2:0]] : '0;
      vazia_q     <= (sp_n == '0);
      cheia_q     <= (sp_n == FULL);
      pop_valid_q <= pop_acc;
      if (pop_acc) dado_pop_q <= mem[sp_m1[SP_W-2:0]];
    end
  end

  assign bus.sp        = sp_q;
  assign bus.topo      = topo_q;
  assign bus.segundo   = segundo_q;
  assign bus.vazia     = vazia_q;
  assign bus.cheia     = cheia_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.dado_pop  = dado_pop_q;

`ifdef PILHA_ERROS_EN
  logic err_ovf, err_unf;
  always_ff @(posedge clock) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (bus.push && !bus.pop && sp_q == FULL) err_ovf <= 1'b1;
      if (bus.pop && sp_q == '0)                err_unf <= 1'b1;
    end
  end
  assign bus.erro_overflow  = err_ovf;
  assign bus.erro_underflow = err_unf;
`else
  assign bus.erro_overflow  = 1'b0;
  assign bus.erro_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pilha.sv
// Directed self-checking bench for the operand stack.
module tb_pilha;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

`ifdef PILHA_ERROS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  pilha_if #(.DATA_W(16), .SP_W(5)) bus ();
  pilha #(.DATA_W(16), .DEPTH(16), .SP_W(5)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  // Apply strobes for one edge, sample 1 time unit after it, then drop the strobes.
  task automatic op(input logic pu, input logic po, input logic c, input logic [15:0] dp, input logic [15:0] du);
    bus.push = pu; bus.pop = po; bus.controle_pilha = c;
    bus.data_pilha = dp; bus.data_ula = du;
    @(posedge clock); #1;
    bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.sp !== 5'd0) begin errors++; $display("FAIL reset_sp got %0d exp 0", bus.sp); end
    checks++; if (bus.topo !== 16'h0 || bus.segundo !== 16'h0) begin errors++; $display("FAIL reset_topo got %h/%h exp 0/0", bus.topo, bus.segundo); end
    checks++; if (bus.vazia !== 1'b1 || bus.cheia !== 1'b0) begin errors++; $display("FAIL reset_flags vazia=%b cheia=%b exp 1/0", bus.vazia, bus.cheia); end
    checks++; if (bus.pop_valid !== 1'b0 || bus.dado_pop !== 16'h0) begin errors++; $display("FAIL reset_pop got %b/%h exp 0/0000", bus.pop_valid, bus.dado_pop); end
    checks++; if (bus.erro_overflow !== 1'b0 || bus.erro_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", bus.erro_overflow, bus.erro_underflow); end
  endtask

  task automatic test_push_src();
    op(1, 0, 0, 16'h1234, 16'h5555);
    checks++; if (bus.sp !== 5'd1 || bus.topo !== 16'h1234 || bus.segundo !== 16'h0) begin errors++; $display("FAIL push1 got sp=%0d topo=%h seg=%h exp 1/1234/0000", bus.sp, bus.topo, bus.segundo); end
    op(1, 0, 1, 16'h5555, 16'hBEEF);
    checks++; if (bus.sp !== 5'd2) begin errors++; $display("FAIL push2_sp got %0d exp 2", bus.sp); end
    checks++; if (bus.topo !== 16'hBEEF || bus.segundo !== 16'h1234) begin errors++; $display("FAIL push2_top got %h/%h exp beef/1234", bus.topo, bus.segundo); end
    checks++; if (bus.vazia !== 1'b0 || bus.pop_valid !== 1'b0) begin errors++; $display("FAIL push2_flags vazia=%b pv=%b exp 0/0", bus.vazia, bus.pop_valid); end
  endtask

  task automatic test_pop();
    op(0, 1, 0, 16'h0, 16'h0);
    checks++; if (bus.dado_pop !== 16'hBEEF || bus.pop_valid !== 1'b1) begin errors++; $display("FAIL pop1 got %h pv=%b exp beef/1", bus.dado_pop, bus.pop_valid); end
    checks++; if (bus.sp !== 5'd1 || bus.topo !== 16'h1234 || bus.segundo !== 16'h0) begin errors++; $display("FAIL pop1_state got sp=%0d topo=%h seg=%h exp 1/1234/0000", bus.sp, bus.topo, bus.segundo); end
    op(0, 1, 0, 16'h0, 16'h0);
    checks++; if (bus.dado_pop !== 16'h1234 || bus.pop_valid !== 1'b1) begin errors++; $display("FAIL pop2 got %h pv=%b exp 1234/1", bus.dado_pop, bus.pop_valid); end
    checks++; if (bus.sp !== 5'd0 || bus.vazia !== 1'b1 || bus.topo !== 16'h0) begin errors++; $display("FAIL pop2_state got sp=%0d vazia=%b topo=%h exp 0/1/0000", bus.sp, bus.vazia, bus.topo); end
    op(0, 0, 0, 16'h0, 16'h0);
    checks++; if (bus.pop_valid !== 1'b0 || bus.dado_pop !== 16'h1234) begin errors++; $display("FAIL pop_idle got pv=%b dado=%h exp 0/1234", bus.pop_valid, bus.dado_pop); end
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) op(1, 0, 0, 16'(i), 16'hDEAD);
  endtask

  task automatic test_overflow();
    do_reset();
    fill16();
    checks++; if (bus.sp !== 5'd16 || bus.cheia !== 1'b1 || bus.topo !== 16'd15 || bus.segundo !== 16'd14) begin errors++; $display("FAIL full got sp=%0d cheia=%b topo=%h seg=%h exp 16/1/000f/000e", bus.sp, bus.cheia, bus.topo, bus.segundo); end
    checks++; if (bus.erro_overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b exp 0", bus.erro_overflow); end
    op(1, 0, 0, 16'hFFFF, 16'h0);
    checks++; if (bus.sp !== 5'd16 || bus.topo !== 16'd15 || bus.cheia !== 1'b1) begin errors++; $display("FAIL ovf_ignored got sp=%0d topo=%h cheia=%b exp 16/000f/1", bus.sp, bus.topo, bus.cheia); end
    checks++; if (bus.erro_overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag got %b exp %b", bus.erro_overflow, ERR_EN); end
    op(0, 0, 0, 16'h0, 16'h0);
    checks++; if (bus.erro_overflow !== ERR_EN) begin errors++; $display("FAIL ovf_sticky got %b exp %b", bus.erro_overflow, ERR_EN); end
  endtask

  task automatic test_replace_full();
    do_reset();
    fill16();
    op(1, 1, 0, 16'h00AA, 16'h0);
    checks++; if (bus.sp !== 5'd16 || bus.topo !== 16'h00AA || bus.segundo !== 16'd14) begin errors++; $display("FAIL repl got sp=%0d topo=%h seg=%h exp 16/00aa/000e", bus.sp, bus.topo, bus.segundo); end
    checks++; if (bus.dado_pop !== 16'd15 || bus.pop_valid !== 1'b1) begin errors++; $display("FAIL repl_pop got %h pv=%b exp 000f/1", bus.dado_pop, bus.pop_valid); end
    checks++; if (bus.erro_overflow !== 1'b0 || bus.cheia !== 1'b1) begin errors++; $display("FAIL repl_flags ovf=%b cheia=%b exp 0/1", bus.erro_overflow, bus.cheia); end
    op(0, 1, 0, 16'h0, 16'h0);
    checks++; if (bus.dado_pop !== 16'h00AA || bus.sp !== 5'd15 || bus.topo !== 16'd14 || bus.cheia !== 1'b0) begin errors++; $display("FAIL repl_then_pop got dado=%h sp=%0d topo=%h cheia=%b exp 00aa/15/000e/0", bus.dado_pop, bus.sp, bus.topo, bus.cheia); end
  endtask

  task automatic test_underflow();
    do_reset();
    op(0, 1, 0, 16'h0, 16'h0);
    checks++; if (bus.sp !== 5'd0 || bus.pop_valid !== 1'b0 || bus.vazia !== 1'b1) begin errors++; $display("FAIL unf got sp=%0d pv=%b vazia=%b exp 0/0/1", bus.sp, bus.pop_valid, bus.vazia); end
    checks++; if (bus.erro_underflow !== ERR_EN) begin errors++; $display("FAIL unf_flag got %b exp %b", bus.erro_underflow, ERR_EN); end
    op(1, 1, 1, 16'h0, 16'h0007);
    checks++; if (bus.sp !== 5'd1 || bus.topo !== 16'h0007 || bus.pop_valid !== 1'b0) begin errors++; $display("FAIL repl_empty got sp=%0d topo=%h pv=%b exp 1/0007/0", bus.sp, bus.topo, bus.pop_valid); end
    checks++; if (bus.erro_underflow !== ERR_EN || bus.erro_overflow !== 1'b0) begin errors++; $display("FAIL repl_empty_err got unf=%b ovf=%b exp %b/0", bus.erro_underflow, bus.erro_overflow, ERR_EN); end
  endtask

  task automatic test_reset_midseq();
    do_reset();
    op(1, 0, 0, 16'h0011, 16'h0);
    op(1, 0, 0, 16'h0022, 16'h0);
    op(0, 1, 0, 16'h0, 16'h0);
    op(1, 0, 0, 16'h0033, 16'h0);
    op(0, 1, 0, 16'h0, 16'h0);  // underflow-free pop: sp 2 -> 1, dado 0033
    checks++; if (bus.sp !== 5'd1 || bus.dado_pop !== 16'h0033 || bus.topo !== 16'h0011) begin errors++; $display("FAIL mid_state got sp=%0d dado=%h topo=%h exp 1/0033/0011", bus.sp, bus.dado_pop, bus.topo); end
    reset = 1'b1;
    op(1, 0, 0, 16'h0044, 16'h0);
    reset = 1'b0;
    checks++; if (bus.sp !== 5'd0 || bus.vazia !== 1'b1 || bus.topo !== 16'h0 || bus.cheia !== 1'b0) begin errors++; $display("FAIL rst_push got sp=%0d vazia=%b topo=%h cheia=%b exp 0/1/0000/0", bus.sp, bus.vazia, bus.topo, bus.cheia); end
    checks++; if (bus.pop_valid !== 1'b0 || bus.dado_pop !== 16'h0 || bus.erro_overflow !== 1'b0 || bus.erro_underflow !== 1'b0) begin errors++; $display("FAIL rst_push_flags got pv=%b dado=%h err=%b%b exp 0/0000/00", bus.pop_valid, bus.dado_pop, bus.erro_overflow, bus.erro_underflow); end
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.controle_pilha = 1'b0;
    bus.data_pilha = '0; bus.data_ula = '0;
    #2;
    test_reset();
    test_push_src();
    test_pop();
    test_overflow();
    test_replace_full();
    test_underflow();
    test_reset_midseq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pilha.md
# pilha

Hardware operand stack for the 16-bit stack processor. It sits directly downstream of the control unit `UC`, consuming its stack strobes (write enable, source select and push/pop intent) and the operand it supplies. It holds up to `DEPTH` words and exposes the top two entries to the temp registers and ULA path. All state changes happen on one clock edge, with registered status and error outputs.

## Interface
- `DATA_W`, 16, word width.
- `DEPTH`, 16, maximum number of entries (power of two, ≥ 2).
- `SP_W`, 5, stack-pointer width; must equal log2(`DEPTH`)+1.

- `clock`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high; empties the stack and clears all flags.
- `push`  in  1  push strobe, one-cycle pulse (maps from `UC` `pilha_wren`).
- `pop`  in  1  pop strobe, one-cycle pulse.
- `controle_pilha`  in  1  push source: 0 = `data_pilha`, 1 = `data_ula`.
- `data_pilha`  in  DATA_W  operand from `UC` (memory word or immediate).
- `data_ula`  in  DATA_W  ULA result.
- `topo`  out  DATA_W  current top entry; 0 when empty.
- `segundo`  out  DATA_W  entry below top; 0 when fewer than 2 entries.
- `sp`  out  SP_W  number of entries, 0..DEPTH.
- `vazia`  out  1  high when `sp`==0.
- `cheia`  out  1  high when `sp`==DEPTH.
- `pop_valid`  out  1  one-cycle pulse the cycle after an accepted pop.
- `dado_pop`  out  DATA_W  value removed by the last accepted pop; holds until the next accepted pop.
- `erro_overflow`  out  1  sticky; see Configuration.
- `erro_underflow`  out  1  sticky; see Configuration.

## Operation
- Storage: register array `mem[0..DEPTH-1]`. Entry `i` is valid when `i < sp`. Top is `mem[sp-1]`.
- Push value `din` = `controle_pilha ? data_ula : data_pilha`.
- Per cycle, with `push`/`pop` sampled:
  - Idle (0/0): no change. `pop_valid`=0.
  - Push only:
    - if !cheia: `mem[sp]`<=din, `sp`<=sp+1.
    - if cheia: ignored; overflow event.
  - Pop only:
    - if !vazia: `dado_pop`<=mem[sp-1], `sp`<=sp-1, `pop_valid`<=1.
    - if vazia: ignored; underflow event.
  - Push+pop (replace top):
    - if !vazia: `dado_pop`<=mem[sp-1], `mem[sp-1]`<=din, `pop_valid`<=1, `sp` unchanged. Legal when cheia; no overflow.
    - if vazia: the push is performed, the pop is ignored, and an underflow event is raised.
- `topo`, `segundo`, `vazia` and `cheia` are registered and reflect post-update state in the same cycle `sp` changes.
- `sp` never wraps: it never exceeds DEPTH and never goes below 0.
- Popped entries are not cleared in `mem`. `topo`/`segundo` mask invalid entries to 0.

## Timing
- Reset values: `sp`=0, `topo`=0, `segundo`=0, `vazia`=1, `cheia`=0, `pop_valid`=0, `dado_pop`=0, `erro_overflow`=0, `erro_underflow`=0. `mem` contents are don't-care.
- Latency: a strobe at edge N updates every output by edge N+1 (one cycle). Back-to-back strobes are accepted every cycle.
- `pop_valid` is high for exactly one cycle per accepted pop or replace.
- `reset` has priority over any strobe in the same cycle. Reset asserted mid-sequence discards the in-flight operation.
- Strobes are level-sampled. Holding `push` high for k cycles performs k pushes; `UC` is responsible for pulsing.

## Configuration
- `PILHA_ERROS_EN` defined:
  - `erro_overflow` sets on an overflow event; `erro_underflow` sets on an underflow event.
  - Both flags stay set until `reset`.
- `PILHA_ERROS_EN` undefined:
  - Both error outputs are tied to 0 and no flag registers are generated.
- Illegal operations are ignored identically in both builds.

## Test plan
- Reset, then push `data_pilha`=0x1234 (`controle_pilha`=0), then push `data_ula`=0xBEEF (`controle_pilha`=1) -> `sp`=2, `topo`=0xBEEF, `segundo`=0x1234, `vazia`=0.
- From that state, pop twice -> `dado_pop`=0xBEEF then 0x1234, `pop_valid` pulses each cycle, final `sp`=0, `vazia`=1, `topo`=0.
- Push 16 values 0..15, then push 0xFFFF -> `cheia`=1, `sp`=16, `topo`=15; `erro_overflow`=1 with the macro, 0 without.
- Full stack, push+pop with din=0x00AA -> `sp`=16, `topo`=0x00AA, `dado_pop`=15, `pop_valid`=1, no overflow.
- Empty stack, pop -> `sp`=0, `pop_valid`=0; `erro_underflow`=1 (macro); then push+pop din=7 -> `sp`=1, `topo`=7.
- Push 3 values, assert `reset` together with `push` -> next cycle `sp`=0, `vazia`=1, all flags 0, `topo`=0.
